// File: rtl/uc_cmd_if.sv
// Command/measurement bundle between the command receiver side
// and the ultrasonic drive mode controller.
interface uc_cmd_if #(
  parameter int AMP_W = 12
);
  logic [4:0]       cmd;
  logic             cmd_vld;
  logic [AMP_W-1:0] amp;
  logic             fault;
  logic [4:0]       freq_idx;
  logic             drive_en;
  logic [1:0]       state;
  logic             sweep_done;
  logic             fault_flg;

  modport master (
    output cmd, cmd_vld, amp, fault,
    input  freq_idx, drive_en, state,
    input  sweep_done, fault_flg
  );

  modport slave (
    input  cmd, cmd_vld, amp, fault,
    output freq_idx, drive_en, state,
    output sweep_done, fault_flg
  );
endinterface

// File: rtl/uc_cmd_ctrl.sv
// Ultrasonic cutter mode controller: command decode, resonance
// sweep keeping the peak-amplitude step, then lock on it.
module uc_cmd_ctrl #(
  parameter int DWELL_CYC = 400000,
  parameter int MAX_IDX   = 20,
  parameter int AMP_W     = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  uc_cmd_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWEEP = 2'd2,
    S_LOCK  = 2'd3
  } state_e;

  localparam int CW = 24;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYC - 1);
  localparam logic [4:0] IDX_LAST = 5'(MAX_IDX);
  localparam logic [4:0] C_RUN   = 5'd21;
  localparam logic [4:0] C_STOP  = 5'd22;
  localparam logic [4:0] C_SWEEP = 5'd23;
  localparam logic [4:0] C_LOCK  = 5'd24;

  state_e           state_q, state_d;
  logic [4:0]       freq_q, freq_d;
  logic [4:0]       set_q, set_d;
  logic             drv_q, drv_d;
  logic             done_q, done_d;
  logic             flg_q, flg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       bidx_q, bidx_d;
  logic [AMP_W-1:0] bamp_q, bamp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      freq_q  <= '0;
      set_q   <= '0;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
      flg_q   <= 1'b0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      bamp_q  <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      set_q   <= set_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      bamp_q  <= bamp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    set_d   = set_q;
    done_d  = 1'b0;
    flg_d   = flg_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    bamp_d  = bamp_q;

    // Lowest priority: sweep stepping; later blocks override it.
    if (state_q == S_SWEEP) begin
      if (cnt_q == CNT_LAST) begin
        if (bus.amp > bamp_q) begin
          bamp_d = bus.amp;
          bidx_d = freq_q;
        end
        if (freq_q < IDX_LAST) begin
          freq_d = freq_q + 5'd1;
          cnt_d  = '0;
        end else begin
          state_d = S_LOCK;
          freq_d  = bidx_d;
          set_d   = bidx_d;
          done_d  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (bus.cmd_vld) begin
      unique case (1'b1)
        (bus.cmd <= IDX_LAST): begin
          set_d = bus.cmd;
          if (state_q == S_RUN) freq_d = bus.cmd;
        end
        (bus.cmd == C_RUN): begin
          if (!flg_q && state_q == S_IDLE) begin
            state_d = S_RUN;
            freq_d  = set_q;
          end else if (!flg_q && state_q == S_LOCK) begin
            state_d = S_RUN;
          end
        end
        (bus.cmd == C_STOP): begin
          state_d = S_IDLE;
          freq_d  = freq_q;
          set_d   = set_q;
          done_d  = 1'b0;
          flg_d   = 1'b0;
          cnt_d   = '0;
          bidx_d  = '0;
          bamp_d  = '0;
        end
        (bus.cmd == C_SWEEP): begin
          if (!flg_q) begin
            state_d = S_SWEEP;
            freq_d  = '0;
            set_d   = set_q;
            done_d  = 1'b0;
            cnt_d   = '0;
            bidx_d  = '0;
            bamp_d  = '0;
          end
        end
        (bus.cmd == C_LOCK): begin
          if (!flg_q && state_q == S_RUN) state_d = S_LOCK;
        end
        default: ;
      endcase
    end

    if (bus.fault) begin
      state_d = S_IDLE;
      freq_d  = freq_q;
      set_d   = set_q;
      done_d  = 1'b0;
      flg_d   = 1'b1;
      cnt_d   = '0;
      bidx_d  = '0;
      bamp_d  = '0;
    end
  end

  assign drv_d = (state_d != S_IDLE);

  assign bus.state      = state_q;
  assign bus.freq_idx   = freq_q;
  assign bus.drive_en   = drv_q;
  assign bus.sweep_done = done_q;
  assign bus.fault_flg  = flg_q;
endmodule

// File: tb/tb_uc_cmd_ctrl.sv
// Scoreboard bench for uc_cmd_ctrl with a short dwell (4 cycles),
// directed command sequences and hand-computed responses.
module tb_uc_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic amp_mode = 1'b0;

  uc_cmd_if #(.AMP_W(12)) bus();

  uc_cmd_ctrl #(
    .DWELL_CYC(4),
    .MAX_IDX(20),
    .AMP_W(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.amp = !amp_mode ? 12'd0 :
    ((bus.freq_idx == 5'd9 || bus.freq_idx == 5'd15) ?
     12'd900 : 12'd100);

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  logic vld_p = 1'b0;

  function automatic logic [9:0] ex(input logic [1:0] st,
    input logic [4:0] fi, input logic de, input logic ff,
    input logic sd);
    return {st, fi, de, ff, sd};
  endfunction

  function automatic logic [9:0] act();
    return {bus.state, bus.freq_idx, bus.drive_en,
            bus.fault_flg, bus.sweep_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
    input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  always @(posedge clk) vld_p <= bus.cmd_vld & rst_n;

  // Monitor: pop an expectation whenever the DUT responds.
  always @(negedge clk) begin
    if (rst_n && (vld_p || bus.sweep_done)) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_empty act=%0h exp=none", act());
      end else begin
        exp_t e;
        e = q.pop_front();
        if (act() !== e.v) begin
          fails++;
          $display("FAIL %s act=%0h exp=%0h", e.nm, act(), e.v);
        end
      end
    end
    if (rst_n && bus.sweep_done) done_cnt++;
  end

  task automatic send(input string nm, input logic [4:0] c,
    input logic [9:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
    @(negedge clk);
    bus.cmd     = c;
    bus.cmd_vld = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic expect_ev(input string nm, input logic [9:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.cmd = '0;
    bus.cmd_vld = 1'b0;
    bus.fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", act(), ex(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // 1: setpoint in IDLE, then RUN
    send("idle_freq", 5'd12, ex(0, 0, 0, 0, 0));
    send("run_entry", 5'd21, ex(1, 12, 1, 0, 0));
    // 2: RUN freq change, ignored code, STOP
    send("run_freq7", 5'd7, ex(1, 7, 1, 0, 0));
    send("ign_26", 5'd26, ex(1, 7, 1, 0, 0));
    send("stop_run", 5'd22, ex(0, 7, 0, 0, 0));

    // 3: sweep with peaks at 9 and 15, tie keeps 9
    amp_mode = 1'b1;
    base = done_cnt;
    send("sweep_entry", 5'd23, ex(2, 0, 1, 0, 0));
    expect_ev("sweep_lock", ex(3, 9, 1, 0, 1));
    repeat (83) @(negedge clk);
    chk("sweep_83", 32'(bus.state), 32'd2);
    @(negedge clk);
    chk("sweep_84", {22'd0, act()}, {22'd0, ex(3, 9, 1, 0, 1)});
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, base + 1);
    send("lock_freq3", 5'd3, ex(3, 9, 1, 0, 0));
    send("lock_run", 5'd21, ex(1, 9, 1, 0, 0));
    send("run_lock", 5'd24, ex(3, 9, 1, 0, 0));
    send("lock_stop", 5'd22, ex(0, 9, 0, 0, 0));

    // 4: abort, restart, all-zero amp lock at 0
    amp_mode = 1'b0;
    base = done_cnt;
    send("sweep2", 5'd23, ex(2, 0, 1, 0, 0));
    repeat (29) @(negedge clk);
    send("sweep_abort", 5'd22, ex(0, 7, 0, 0, 0));
    repeat (100) @(negedge clk);
    chk("abort_nodone", done_cnt, base);
    send("sweep3", 5'd23, ex(2, 0, 1, 0, 0));
    repeat (10) @(negedge clk);
    chk("sweep3_mid", 32'(bus.freq_idx), 32'd2);
    send("sweep_restart", 5'd23, ex(2, 0, 1, 0, 0));
    expect_ev("zero_lock", ex(3, 0, 1, 0, 1));
    for (int i = 0; i < 200 && !bus.sweep_done; i++)
      @(negedge clk);
    chk("zero_lock_seen", 32'(bus.sweep_done), 32'd1);
    @(negedge clk);
    chk("done_restart", done_cnt, base + 1);
    send("stop2", 5'd22, ex(0, 0, 0, 0, 0));

    // 5: fault handling
    send("run2", 5'd21, ex(1, 0, 1, 0, 0));
    send("run_freq5", 5'd5, ex(1, 5, 1, 0, 0));
    bus.fault = 1'b1;
    @(negedge clk);
    chk("fault_trip", {22'd0, act()}, {22'd0, ex(0, 5, 0, 1, 0)});
    send("run_in_fault", 5'd21, ex(0, 5, 0, 1, 0));
    bus.fault = 1'b0;
    send("run_flg_ign", 5'd21, ex(0, 5, 0, 1, 0));
    send("stop_clr", 5'd22, ex(0, 5, 0, 0, 0));
    send("run_after", 5'd21, ex(1, 5, 1, 0, 0));

    // 6: fault same cycle as command, then reset mid-sweep
    expect_ev("fault_cmd", ex(0, 5, 0, 1, 0));
    @(negedge clk);
    bus.cmd = 5'd7;
    bus.cmd_vld = 1'b1;
    bus.fault = 1'b1;
    @(negedge clk);
    bus.cmd_vld = 1'b0;
    bus.fault = 1'b0;
    send("stop_clr2", 5'd22, ex(0, 5, 0, 0, 0));
    base = done_cnt;
    send("sweep4", 5'd23, ex(2, 0, 1, 0, 0));
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", act(), ex(0, 0, 0, 0, 0));
    repeat (50) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hold", act(), ex(0, 0, 0, 0, 0));
    chk("rst_nodone", done_cnt, base);
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
